// File: rtl/led_seq_pkg.sv
// Shared mode encodings and the one-hot helper for the LED sequencer.
package led_seq_pkg;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [1:0] MODE_SCAN_DN = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  // Widest select supported; callers truncate the result to their own 2**SEL_W.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_LEDS  = 2 ** MAX_SEL_W;

  function automatic logic [MAX_LEDS-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_LEDS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_onehot_sequencer_if.sv
// Switch-side inputs and LED-side outputs of the sequencer, bundled for port lists.
interface led_onehot_sequencer_if #(
  parameter int SEL_W = 2
) ();

  logic [SEL_W-1:0]      sel;
  logic                  en;
  logic [1:0]            mode;
  logic [2**SEL_W-1:0]   leds;
  logic [SEL_W-1:0]      pos;
  logic                  tick;

  modport master (output sel, output en, output mode, input leds, input pos, input tick);
  modport slave  (input sel, input en, input mode, output leds, output pos, output tick);

endinterface

// File: rtl/tick_prescaler.sv
// Free-running step/blink prescaler; clr restarts the period so a new mode gets a full first interval.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_tc;

  assign at_tc = (cnt == CNT_TC);
  // A clear landing on terminal count swallows that tick.
  assign tick  = at_tc && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || at_tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_onehot_sequencer.sv
// Registered one-hot LED driver: direct decode, up/down chaser or blink of the selected LED.
module led_onehot_sequencer
  import led_seq_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int TICK_DIV = 50000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  led_onehot_sequencer_if.slave  bus
);

  localparam int N_LEDS = 2 ** SEL_W;

  logic [SEL_W-1:0]  sel_m, sel_s;
  logic              en_m, en_s;
  logic [1:0]        mode_m, mode_s, mode_prev;
  logic              chg;
  logic              tick;
  logic [SEL_W-1:0]  pos, pos_nx;
  logic              blink_ph, blink_nx;
  logic [N_LEDS-1:0] leds, leds_nx;

  // Switches are asynchronous to clk; everything downstream sees only the _s copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_m  <= '0;
      sel_s  <= '0;
      en_m   <= 1'b0;
      en_s   <= 1'b0;
      mode_m <= MODE_DIRECT;
      mode_s <= MODE_DIRECT;
    end else begin
      sel_m  <= bus.sel;
      sel_s  <= sel_m;
      en_m   <= bus.en;
      en_s   <= en_m;
      mode_m <= bus.mode;
      mode_s <= mode_m;
    end
  end

  assign chg = (mode_s != mode_prev);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (chg),
    .tick  (tick)
  );

  always_comb begin
    pos_nx   = pos;
    blink_nx = blink_ph;
    leds_nx  = '0;
    // Disabled: position and blink phase freeze, LEDs go dark.
    if (en_s) begin
      if (chg) begin
        blink_nx = 1'b1;
      end else if (mode_s == MODE_BLINK && tick) begin
        blink_nx = ~blink_ph;
      end
      case (mode_s)
        MODE_SCAN_UP: if (tick) pos_nx = pos + 1'b1;
        MODE_SCAN_DN: if (tick) pos_nx = pos - 1'b1;
        default:      pos_nx = sel_s;
      endcase
      if (!(mode_s == MODE_BLINK && !blink_nx)) begin
        leds_nx = N_LEDS'(onehot(MAX_SEL_W'(pos_nx)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_prev <= MODE_DIRECT;
      pos       <= '0;
      blink_ph  <= 1'b1;
      leds      <= '0;
    end else begin
      mode_prev <= mode_s;
      pos       <= pos_nx;
      blink_ph  <= blink_nx;
      leds      <= leds_nx;
    end
  end

  assign bus.leds = leds;
  assign bus.pos  = pos;
  assign bus.tick = tick;

endmodule
